// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: synchronizes and debounces the PS/2 clock, decodes 11-bit
// odd-parity frames and queues good bytes in a 4-entry first-word-fall-through FIFO.
module ps2_rx_fifo #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2clk,
  input  logic       ps2dat,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic [2:0] count,
  output logic       busy,
  output logic       frame_err,
  output logic       overflow
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          sample;

  state_e        state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          err_q, err_d;
  logic          push;

  logic [3:0][7:0] mem_q;
  logic [1:0]      wr_ptr_q, rd_ptr_q;
  logic [2:0]      count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            pop, full, do_push;

  // Both pins idle high, so synchronizers reset to 1 to avoid a fake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2dat;
      dat_s2_q <= dat_s1_q;
    end
  end

  // fcnt counts consecutive samples that disagree with the filtered level.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
      else                               fcnt_d = fcnt_q + 1'b1;
    end
  end

  assign sample = filt_q & ~filt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tcnt_d  = '0;
    err_d   = 1'b0;
    push    = 1'b0;
    if (state_q != S_IDLE && !sample) tcnt_d = tcnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (sample && !dat_s2_q) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (sample) begin
          shreg_d = {dat_s2_q, shreg_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (sample) begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          if ((^shreg_q ^ par_q) && dat_s2_q) push  = 1'b1;
          else                                err_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Line stalled mid-frame: abandon the partial byte.
    if (state_q != S_IDLE && !sample && tcnt_q == TW'(TIMEOUT - 1)) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      tcnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
    end
  end

  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign pop     = rd_en && (count_q != 3'd0);
  assign full    = (count_q == 3'd4);
  assign do_push = push && (!full || pop);
  assign ovf_d   = ovf_q | (push & full & ~pop);
  assign count_d = count_q + {2'b00, do_push} - {2'b00, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= shreg_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rd_data   = mem_q[rd_ptr_q];
  assign rd_valid  = (count_q != 3'd0);
  assign count     = count_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_err = err_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: a scoreboard queue holds expected bytes,
// a negedge monitor checks every pop and counts frame_err pulses.
module tb_ps2_rx_fifo;
  localparam int FL   = 4;
  localparam int TO   = 300;
  localparam int HALF = 20;

  logic       clk = 1'b0, rst_n = 1'b0, ps2clk = 1'b1, ps2dat = 1'b1, rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, busy, frame_err, overflow;
  logic [2:0] count;

  int checks = 0, errors = 0;
  int err_seen = 0, exp_err = 0;
  int lat = 0;
  logic [7:0] sb[$];

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2clk(ps2clk), .ps2dat(ps2dat), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .busy(busy),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : mon
    logic [7:0] e;
    if (frame_err === 1'b1) err_seen++;
    if (rd_en && rd_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got %02h required no data", rd_data);
      end else begin
        e = sb.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL pop_data got %02h required %02h", rd_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 bit; optionally pulse rd_en so it is high on the pop_at-th edge after the fall.
  task automatic ps2_bit(input logic b, input int pop_at);
    ps2dat = b;
    cyc(HALF);
    ps2clk = 1'b0;
    if (pop_at > 0) begin
      cyc(pop_at - 1);
      rd_en = 1'b1;
      cyc(1);
      rd_en = 1'b0;
      cyc(HALF - pop_at);
    end else begin
      cyc(HALF);
    end
    ps2clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic bad_stop,
                            input int pop_at);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], 0);
    ps2_bit((~^d) ^ flip_par, 0);
    ps2_bit(~bad_stop, pop_at);
    cyc(4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end

  initial begin
    int found;
    int busy_seen;
    logic [7:0] d;
    // reset state
    cyc(3);
    @(negedge clk);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    cyc(10);

    // good frame 0x1C, measuring stop-fall to push latency
    d = 8'h1C;
    sb.push_back(d);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], 0);
    ps2_bit(1'b0, 0);
    ps2dat = 1'b1;
    cyc(HALF);
    ps2clk = 1'b0;
    for (int n = 1; n < HALF; n++) begin
      cyc(1);
      if (rd_valid) begin lat = n; break; end
    end
    chk("push_seen", lat > 0, 1);
    cyc(HALF - lat);
    ps2clk = 1'b1;
    if (lat == 0) lat = 6;
    cyc(4);
    chk("good_rd_valid", rd_valid, 1);
    chk("good_rd_data", rd_data, 8'h1C);
    chk("good_count", count, 1);
    chk("good_no_err", err_seen, 0);
    rd_en = 1'b1; cyc(1); rd_en = 1'b0;
    chk("good_drained", rd_valid, 0);

    // bad parity
    send_frame(8'h1C, 1'b1, 1'b0, 0);
    exp_err++;
    chk("par_err_count", err_seen, exp_err);
    chk("par_count", count, 0);
    chk("par_busy", busy, 0);

    // bad stop bit
    send_frame(8'h33, 1'b0, 1'b1, 0);
    exp_err++;
    chk("stop_err_count", err_seen, exp_err);
    chk("stop_count", count, 0);

    // timeout: start + 3 data bits, then clock held high
    ps2_bit(1'b0, 0);
    ps2_bit(1'b0, 0);
    ps2_bit(1'b0, 0);
    ps2dat = 1'b1;
    cyc(HALF);
    ps2clk = 1'b0;
    found = 0;
    for (int n = 1; n < TO + lat + 60; n++) begin
      @(negedge clk);
      if (n == HALF) begin
        chk("to_busy_mid", busy, 1);
        ps2clk = 1'b1;
      end
      if (frame_err) begin found = n; break; end
    end
    ps2clk = 1'b1;
    checks++;
    if (found < lat + TO || found > lat + TO + 1) begin
      errors++;
      $display("FAIL timeout_delay got %0d required %0d..%0d", found, lat + TO, lat + TO + 1);
    end
    exp_err++;
    cyc(3);
    chk("to_busy", busy, 0);
    chk("to_count", count, 0);
    chk("to_err_count", err_seen, exp_err);

    // glitch shorter than the filter
    cyc(10);
    ps2clk = 1'b0;
    cyc(FL - 1);
    ps2clk = 1'b1;
    busy_seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (busy) busy_seen = 1;
    end
    chk("glitch_busy", busy_seen, 0);
    chk("glitch_err", err_seen, exp_err);
    cyc(5);

    // overflow: 0x01..0x05 with no reads
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) sb.push_back(8'(i));
      send_frame(8'(i), 1'b0, 1'b0, 0);
    end
    chk("ovf_count", count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", rd_data, 8'h01);
    rd_en = 1'b1; cyc(4); rd_en = 1'b0;
    chk("ovf_drained", rd_valid, 0);
    chk("ovf_sticky", overflow, 1);
    rd_en = 1'b1; cyc(1); rd_en = 1'b0;
    chk("empty_pop_count", count, 0);

    // reset mid-frame
    ps2_bit(1'b0, 0);
    ps2_bit(1'b1, 0);
    ps2_bit(1'b1, 0);
    cyc(2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_frame_err", frame_err, 0);
    chk("mid_rst_overflow", overflow, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(8);
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, 0);
    chk("post_rst_data", rd_data, 8'h5A);
    chk("post_rst_count", count, 1);
    chk("post_rst_err", err_seen, exp_err);
    rd_en = 1'b1; cyc(1); rd_en = 1'b0;

    // full FIFO with a pop on the push edge of 0xF0
    for (int i = 0; i < 4; i++) begin
      sb.push_back(8'hA1 + 8'(i));
      send_frame(8'hA1 + 8'(i), 1'b0, 1'b0, 0);
    end
    chk("full_count", count, 4);
    sb.push_back(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b0, lat);
    chk("pp_count", count, 4);
    chk("pp_overflow", overflow, 0);
    chk("pp_head", rd_data, 8'hA2);
    rd_en = 1'b1; cyc(4); rd_en = 1'b0;
    chk("pp_drained", rd_valid, 0);
    chk("sb_empty", sb.size(), 0);
    chk("final_err", err_seen, exp_err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
